// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin UART transmitter driven by an external mid-bit tick.
// Optional even parity after D7 when UART_TX_PARITY_EN is defined.
module uart_tx_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic       clk_bps,
  output logic       bps_start,
  output logic       txd,
  output logic       busy,
  output logic       grant_id,
  output logic [1:0] dbg_state
);

  // Handshake: reqN_valid is sampled only in IDLE; reqN_ready is a single-cycle
  // combinational accept pulse in that same cycle, and the byte is latched on its edge.

  typedef enum logic [1:0] {IDLE, ARM, SHIFT, DONE} state_t;

`ifdef UART_TX_PARITY_EN
  localparam logic [3:0] LAST_TICK = 4'd12;
`else
  localparam logic [3:0] LAST_TICK = 4'd11;
`endif

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [3:0] cnt_q, cnt_d;
  logic       txd_q, txd_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       pick;
  logic [3:0] nxt_cnt;
  logic [2:0] bit_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      cnt_q   <= 4'd0;
      txd_q   <= 1'b1;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    txd_d      = txd_q;
    grant_d    = grant_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    bps_start  = 1'b0;
    busy       = 1'b0;
    pick       = 1'b0;
    nxt_cnt    = cnt_q + 4'd1;
    // tick 2 carries D0, so the data index is the tick number minus two (mod 8)
    bit_sel    = nxt_cnt[2:0] - 3'd2;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        txd_d = 1'b1;
        if (req0_valid || req1_valid) begin
          pick       = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          req0_ready = ~pick;
          req1_ready = pick;
          data_d     = pick ? req1_data : req0_data;
          grant_d    = pick;
          last_d     = pick;
          state_d    = ARM;
        end
      end
      ARM: begin
        bps_start = 1'b1;
        busy      = 1'b1;
        txd_d     = 1'b1;
        if (clk_bps) begin
          cnt_d   = 4'd1;
          txd_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bps_start = 1'b1;
        busy      = 1'b1;
        if (clk_bps) begin
          cnt_d = nxt_cnt;
          if (nxt_cnt == LAST_TICK) begin
            txd_d   = 1'b1;
            state_d = DONE;
          end else if (nxt_cnt <= 4'd9) begin
            txd_d = data_q[bit_sel];
`ifdef UART_TX_PARITY_EN
          end else if (nxt_cnt == 4'd10) begin
            txd_d = ^data_q;
`endif
          end else begin
            txd_d = 1'b1;
          end
        end
      end
      DONE: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign txd       = txd_q;
  assign grant_id  = grant_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: directed frames, serial decode monitor,
// ready/grant monitor fed from expected queues.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       gen_tick = 1'b0, force_tick = 1'b0;
  logic       clk_bps;
  logic       bps_start, txd, busy, grant_id;
  logic [1:0] dbg_state;

  assign clk_bps = gen_tick | force_tick;

  uart_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .clk_bps(clk_bps), .bps_start(bps_start), .txd(txd),
    .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_TICKS = 12;
`else
  localparam int FRAME_TICKS = 11;
`endif

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic       exp_gnt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // baud generator model: one tick every 16 clocks while bps_start is high
  int bcnt = 0;
  always @(negedge clk) begin
    if (bps_start) begin
      if (bcnt == 15) begin gen_tick = 1'b1; bcnt = 0; end
      else begin gen_tick = 1'b0; bcnt++; end
    end else begin
      gen_tick = 1'b0;
      bcnt = 0;
    end
  end

  // serial monitor: capture txd after each consumed tick, compare frame at the last tick
  int          nb = 0;
  logic [12:0] cap = '0;
  logic [12:0] ef;
  logic [7:0]  eb;
  logic        prev_bps = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      nb = 0;
      prev_bps = 1'b0;
    end else begin
      if (clk_bps && prev_bps) begin
        nb++;
        if (nb == 1) cap = '0;
        cap[nb] = txd;
        if (nb == FRAME_TICKS) begin
          check("frame_end", {29'd0, bps_start, busy, txd}, 32'b001);
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_frame: got %0h expected none", cap);
          end else begin
            eb = exp_q.pop_front();
            ef = '0;
            for (int i = 0; i < 8; i++) ef[2 + i] = eb[i];
`ifdef UART_TX_PARITY_EN
            ef[10] = ^eb;
            ef[11] = 1'b1;
            ef[12] = 1'b1;
`else
            ef[10] = 1'b1;
            ef[11] = 1'b1;
`endif
            check("frame_bits", {19'd0, cap}, {19'd0, ef});
          end
          nb = 0;
        end
      end else if (bps_start && nb > 0) begin
        check("bit_hold", txd, cap[nb]);
      end else if (bps_start && nb == 0) begin
        check("arm_txd", txd, 1'b1);
      end
      if (!bps_start) check("idle_high", txd, 1'b1);
      prev_bps = bps_start;
    end
  end

  // accept monitor: every ready pulse must match the next expected grant
  logic chk_gid = 1'b0;
  logic gid_exp = 1'b0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      chk_gid = 1'b0;
    end else begin
      if (chk_gid) begin
        check("grant_id", grant_id, gid_exp);
        check("busy_after_accept", busy, 1'b1);
        chk_gid = 1'b0;
      end
      if (req0_ready || req1_ready) begin
        check("ready_in_idle", {30'd0, bps_start, req0_ready & req1_ready}, 32'd0);
        if (exp_gnt_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_ready: got r0=%0b r1=%0b expected none", req0_ready, req1_ready);
        end else begin
          gid_exp = exp_gnt_q.pop_front();
          check("ready_id", req1_ready, gid_exp);
          chk_gid = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic id, input logic [7:0] d);
    int t = 0;
    exp_gnt_q.push_back(id);
    exp_q.push_back(d);
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else begin req0_valid = 1'b1; req0_data = d; end
    #1;
    while (!(id ? req1_ready : req0_ready) && t < 2000) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 2000) check("send_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bps_start) && t < 5000) begin
      @(negedge clk); t++;
    end
    check("drain_timeout", {31'd0, t >= 5000}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int t;
    int acc;
    // reset values
    repeat (2) @(posedge clk);
    #1 check("reset_vals", {27'd0, txd, bps_start, busy, req0_ready, req1_ready}, 32'b10000);
    check("reset_grant", {30'd0, grant_id, dbg_state}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // idle with no requests
    repeat (100) begin
      @(negedge clk); #1;
      check("idle", {27'd0, txd, bps_start, busy, req0_ready, req1_ready}, 32'b10000);
    end

    // both requesters held valid: req0 wins first contention, then alternate
    exp_gnt_q.push_back(1'b0); exp_q.push_back(8'hA0);
    exp_gnt_q.push_back(1'b1); exp_q.push_back(8'h0B);
    exp_gnt_q.push_back(1'b0); exp_q.push_back(8'hA0);
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hA0;
    req1_valid = 1'b1; req1_data = 8'h0B;
    acc = 0; t = 0;
    while (acc < 3 && t < 3000) begin
      #1;
      if (req0_ready || req1_ready) acc++;
      if (acc == 3) begin
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
      t++;
    end
    check("rr_accepts", 32'(acc), 32'd3);
    drain();

    // single requester, alternating bit pattern
    send(1'b0, 8'h55);
    drain();

    // ticks in IDLE are ignored; a request raised mid-frame waits for DONE
    repeat (3) begin
      @(negedge clk) force_tick = 1'b1;
      @(negedge clk) force_tick = 1'b0;
      #1 check("idle_tick", {29'd0, txd, bps_start, busy}, 32'b100);
    end
    send(1'b0, 8'h96);
    t = 0;
    while (nb < 3 && t < 1000) begin @(negedge clk); t++; end
    check("mid_wait", {31'd0, t >= 1000}, 32'd0);
    exp_gnt_q.push_back(1'b1); exp_q.push_back(8'hC3);
    @(negedge clk); req1_valid = 1'b1; req1_data = 8'hC3;
    #1 check("no_ready_midframe", {30'd0, req0_ready, req1_ready}, 32'd0);
    t = 0;
    while (!req1_ready && t < 2000) begin @(negedge clk); #1; t++; end
    check("late_ready_timeout", {31'd0, t >= 2000}, 32'd0);
    @(posedge clk); #1 req1_valid = 1'b0;
    drain();

    // asynchronous reset in the middle of a 0xFF frame
    send(1'b0, 8'hFF);
    t = 0;
    while (nb < 4 && t < 1000) begin @(posedge clk); #2; t++; end
    check("abort_wait", {31'd0, t >= 1000}, 32'd0);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", {29'd0, txd, bps_start, busy}, 32'b100);
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_gnt_q.delete();
    rst_n = 1'b1;
    send(1'b0, 8'h3C);
    drain();

`ifdef UART_TX_PARITY_EN
    // parity bit set for odd number of ones
    send(1'b1, 8'h07);
    drain();
`endif

    check("exp_q_empty", exp_q.size(), 32'd0);
    check("exp_gnt_q_empty", exp_gnt_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
